// File: rtl/avalon_mm_responder.sv
// ---------------------------------------------------------------------------
// avalon_mm_responder
//
// Avalon-MM responder backed by a word-addressed internal memory. It answers
// single reads and writes with a fixed number of wait states per transfer
// type (via waitrequest). It flags initiator protocol violations in a sticky
// bit and counts completed transfers.
//
// Parameters
//   NBDATABYTES  data bus width in bytes (DW = 8*NBDATABYTES)
//   NBADDRBITS   word-address width, memory depth 2**NBADDRBITS
//   READDELAY    wait states per read  (0..15)
//   WRITEDELAY   wait states per write (0..15)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   address         word address
//   byteenable      byte-lane enables
//   read / write    transfer requests
//   writedata       write data
//   readdata        read data, non-zero only in a read completion cycle
//   waitrequest     stall, combinational from read/write and the wait counter
//   protocol_error  sticky initiator-violation flag
//   nb_reads        completed-read counter (wraps)
//   nb_writes       completed-write counter (wraps)
// ---------------------------------------------------------------------------
module avalon_mm_responder #(
    parameter int NBDATABYTES = 2,
    parameter int NBADDRBITS  = 8,
    parameter int READDELAY   = 1,
    parameter int WRITEDELAY  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBADDRBITS-1:0]    address,
    input  logic [NBDATABYTES-1:0]   byteenable,
    input  logic                     read,
    input  logic                     write,
    input  logic [8*NBDATABYTES-1:0] writedata,
    output logic [8*NBDATABYTES-1:0] readdata,
    output logic                     waitrequest,
    output logic                     protocol_error,
    output logic [15:0]              nb_reads,
    output logic [15:0]              nb_writes
);

    localparam int DW    = 8 * NBDATABYTES;
    localparam int DEPTH = 1 << NBADDRBITS;
    localparam logic [3:0] RD_DELAY = 4'(READDELAY);
    localparam logic [3:0] WR_DELAY = 4'(WRITEDELAY);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                   state_reg, state_next;
    logic [3:0]               cnt_reg, cnt_next;
    logic                     is_write_reg, is_write_next;
    logic [NBADDRBITS-1:0]    addr_cap_reg;
    logic [NBDATABYTES-1:0]   be_cap_reg;
    logic [DW-1:0]            wdata_cap_reg;
    logic                     err_reg;
    logic [15:0]              nb_reads_reg, nb_writes_reg;
    logic [DW-1:0]            mem_reg [DEPTH];

    logic                     req;
    logic [3:0]               delay;
    logic                     at_delay;
    logic                     capture;
    logic                     complete;
    logic                     err_set;
    logic [DW-1:0]            rd_word;

    // Exactly one request type active; read&write together is a violation
    // and is never treated as a transfer.
    assign req      = read ^ write;
    assign delay    = read ? RD_DELAY : WR_DELAY;
    assign at_delay = (cnt_reg == delay);

    // Gated by rst so the stall output is low while reset is held.
    assign waitrequest = rst & req & ~at_delay;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        is_write_next = is_write_reg;
        capture       = 1'b0;
        complete      = 1'b0;
        err_set       = read & write;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    // cnt is always 0 in IDLE, so at_delay means a zero-delay transfer
                    if (at_delay) begin
                        complete = 1'b1;
                    end else begin
                        state_next    = WAIT;
                        cnt_next      = 4'd1;
                        capture       = 1'b1;
                        is_write_next = write;
                    end
                end
            end
            WAIT: begin
                if (!req || (write != is_write_reg)) begin
                    // request dropped or changed type: abandon the transfer
                    err_set    = 1'b1;
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    if ((address != addr_cap_reg) || (byteenable != be_cap_reg) ||
                        (write && (writedata != wdata_cap_reg)))
                        err_set = 1'b1;
                    if (at_delay) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            is_write_reg  <= 1'b0;
            addr_cap_reg  <= '0;
            be_cap_reg    <= '0;
            wdata_cap_reg <= '0;
            err_reg       <= 1'b0;
            nb_reads_reg  <= 16'd0;
            nb_writes_reg <= 16'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            is_write_reg <= is_write_next;
            if (capture) begin
                addr_cap_reg  <= address;
                be_cap_reg    <= byteenable;
                wdata_cap_reg <= writedata;
            end
            if (err_set)
                err_reg <= 1'b1;
            if (complete && read)
                nb_reads_reg <= nb_reads_reg + 16'd1;
            if (complete && write)
                nb_writes_reg <= nb_writes_reg + 16'd1;
        end
    end

    // Memory must clear on reset, so it is a register array rather than RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (complete && write) begin
            for (int b = 0; b < NBDATABYTES; b++)
                if (byteenable[b])
                    mem_reg[address][b*8 +: 8] <= writedata[b*8 +: 8];
        end
    end

    assign rd_word = mem_reg[address];

    generate
        for (genvar gi = 0; gi < NBDATABYTES; gi++) begin : g_rd_lane
            assign readdata[gi*8 +: 8] = (rst && complete && read && byteenable[gi]) ?
                                         rd_word[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign protocol_error = err_reg;
    assign nb_reads       = nb_reads_reg;
    assign nb_writes      = nb_writes_reg;

endmodule

// File: tb/tb_avalon_mm_responder.sv
module tb_avalon_mm_responder;

    localparam int RD = 1;
    localparam int WD = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (RD=1, WD=2)
    logic        rst;
    logic [7:0]  address;
    logic [1:0]  byteenable;
    logic        read, write;
    logic [15:0] writedata, readdata;
    logic        waitrequest, protocol_error;
    logic [15:0] nb_reads, nb_writes;

    // zero-delay instance
    logic        rst_z;
    logic [7:0]  address_z;
    logic [1:0]  byteenable_z;
    logic        read_z, write_z;
    logic [15:0] writedata_z, readdata_z;
    logic        waitrequest_z, protocol_error_z;
    logic [15:0] nb_reads_z, nb_writes_z;

    avalon_mm_responder #(.NBDATABYTES(2), .NBADDRBITS(8), .READDELAY(RD), .WRITEDELAY(WD)) dut (
        .clk(clk), .rst(rst), .address(address), .byteenable(byteenable),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .protocol_error(protocol_error),
        .nb_reads(nb_reads), .nb_writes(nb_writes));

    avalon_mm_responder #(.NBDATABYTES(2), .NBADDRBITS(8), .READDELAY(0), .WRITEDELAY(0)) dut_z (
        .clk(clk), .rst(rst_z), .address(address_z), .byteenable(byteenable_z),
        .read(read_z), .write(write_z), .writedata(writedata_z), .readdata(readdata_z),
        .waitrequest(waitrequest_z), .protocol_error(protocol_error_z),
        .nb_reads(nb_reads_z), .nb_writes(nb_writes_z));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // reference model
    logic [15:0] model_mem [256];
    int          m_reads, m_writes;
    bit          m_err;

    typedef struct {
        bit          is_wr;
        logic [15:0] rdata;
        int          waits;
        logic [15:0] nbr;
        logic [15:0] nbw;
        bit          err;
    } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;
        m_reads = 0; m_writes = 0; m_err = 0;
    endtask

    // Issue one transfer starting just after a rising edge; returns just after
    // the rising edge that ends the completion cycle, request still asserted.
    task automatic xfer(input bit is_wr, input logic [7:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input logic [7:0] a_alt, input bit perturb);
        exp_t e;
        logic [7:0] eff;
        int n;
        eff     = perturb ? a_alt : a;
        e.is_wr = is_wr;
        e.waits = is_wr ? WD : RD;
        e.nbr   = 16'(m_reads);
        e.nbw   = 16'(m_writes);
        e.err   = m_err;
        e.rdata = 16'h0;
        if (is_wr) begin
            for (int b = 0; b < 2; b++)
                if (be[b]) model_mem[eff][b*8 +: 8] = wd[b*8 +: 8];
            m_writes = (m_writes + 1) % 65536;
        end else begin
            for (int b = 0; b < 2; b++)
                if (be[b]) e.rdata[b*8 +: 8] = model_mem[eff][b*8 +: 8];
            m_reads = (m_reads + 1) % 65536;
        end
        if (perturb) m_err = 1;
        sb.push_back(e);
        $display("xfer %s addr=%02h be=%b wd=%04h exp_rd=%04h", is_wr ? "WR" : "RD", a, be, wd, e.rdata);
        read = !is_wr; write = is_wr; address = a; byteenable = be; writedata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (!waitrequest) break;
            if (n > 20) begin
                chk("xfer_timeout", 32'(n), 32'(e.waits));
                break;
            end
            @(posedge clk); #1;
            if (perturb) address = a_alt;
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        read = 0; write = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // monitor / scoreboard for the main instance
    int wcnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            wcnt = 0;
        end else if (read ^ write) begin
            if (waitrequest) begin
                wcnt++;
            end else begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("wait_states", 32'(wcnt), 32'(e.waits));
                    chk("readdata", 32'(readdata), 32'(e.rdata));
                    chk("nb_reads", 32'(nb_reads), 32'(e.nbr));
                    chk("nb_writes", 32'(nb_writes), 32'(e.nbw));
                    chk("protocol_error", 32'(protocol_error), 32'(e.err));
                end
                wcnt = 0;
            end
        end else begin
            wcnt = 0;
            chk("waitreq_idle", 32'(waitrequest), 32'd0);
            chk("readdata_idle", 32'(readdata), 32'd0);
        end
    end

    // zero-delay instance: count any stall cycles
    int hi_z = 0;
    bit done_z = 0;
    always @(negedge clk) if (rst_z && waitrequest_z) hi_z++;

    initial begin
        rst_z = 1; read_z = 0; write_z = 0; address_z = 0; byteenable_z = 2'b11; writedata_z = 0;
        #1 rst_z = 0;
        repeat (2) @(posedge clk);
        #1 rst_z = 1;
        write_z = 1;
        for (int i = 0; i < 65536; i++) begin
            if (i == 65535) chk("z_nb_writes_ffff", 32'(nb_writes_z), 32'hFFFF);
            address_z = 8'($urandom); writedata_z = 16'($urandom);
            @(posedge clk); #1;
        end
        chk("z_nb_writes_wrap", 32'(nb_writes_z), 32'd0);
        $display("z: 65536 writes issued, nb_writes=%0h", nb_writes_z);
        address_z = 8'h42; writedata_z = 16'h1357;
        @(posedge clk); #1;
        write_z = 0; read_z = 1;
        #1 chk("z_read_back", 32'(readdata_z), 32'h1357);
        chk("z_nb_writes_one", 32'(nb_writes_z), 32'd1);
        // asynchronous reset in mid-cycle, checked before the next edge
        rst_z = 0;
        #1;
        chk("z_rst_nb_writes", 32'(nb_writes_z), 32'd0);
        chk("z_rst_readdata", 32'(readdata_z), 32'd0);
        chk("z_rst_waitreq", 32'(waitrequest_z), 32'd0);
        chk("z_rst_err", 32'(protocol_error_z), 32'd0);
        @(posedge clk); #1 rst_z = 1;
        #1 chk("z_mem_cleared", 32'(readdata_z), 32'd0);
        read_z = 0;
        chk("z_no_stall", 32'(hi_z), 32'd0);
        done_z = 1;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w;
        logic [7:0]  a;
        logic [1:0]  be;
        logic [15:0] wd;
        rst = 1; read = 0; write = 0; address = 0; byteenable = 0; writedata = 0;
        model_reset();
        #1 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readdata", 32'(readdata), 32'd0);
        chk("rst_waitreq", 32'(waitrequest), 32'd0);
        chk("rst_err", 32'(protocol_error), 32'd0);
        chk("rst_nb_reads", 32'(nb_reads), 32'd0);
        chk("rst_nb_writes", 32'(nb_writes), 32'd0);
        rst = 1;
        @(posedge clk); #1;

        xfer(1, 8'h10, 2'b11, 16'hBEEF, 8'h00, 0);
        xfer(0, 8'h10, 2'b11, 16'h0000, 8'h00, 0);
        idle(2);
        xfer(1, 8'h10, 2'b01, 16'h1234, 8'h00, 0);
        idle(1);
        xfer(0, 8'h10, 2'b11, 16'h0000, 8'h00, 0);

        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 15));
            be = 2'($urandom_range(0, 3));
            wd = 16'($urandom);
            xfer(w, a, be, wd, 8'h00, 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);
        chk("tot_nb_reads", 32'(nb_reads), 32'(m_reads));
        chk("tot_nb_writes", 32'(nb_writes), 32'(m_writes));
        chk("no_err_yet", 32'(protocol_error), 32'd0);

        // address changes during the wait state
        xfer(1, 8'h11, 2'b11, 16'hCAFE, 8'h00, 0);
        xfer(0, 8'h10, 2'b11, 16'h0000, 8'h11, 1);
        idle(1);
        chk("err_addr_change", 32'(protocol_error), 32'd1);

        // asynchronous reset mid-cycle
        @(posedge clk); #3 rst = 0;
        #1;
        chk("arst_err", 32'(protocol_error), 32'd0);
        chk("arst_nb_reads", 32'(nb_reads), 32'd0);
        chk("arst_nb_writes", 32'(nb_writes), 32'd0);
        model_reset();
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;

        // reset during a write's wait state aborts it
        write = 1; address = 8'h20; byteenable = 2'b11; writedata = 16'hAAAA;
        @(posedge clk); #3 rst = 0;
        #1 chk("abort_waitreq", 32'(waitrequest), 32'd0);
        write = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;
        chk("abort_nb_writes", 32'(nb_writes), 32'd0);
        xfer(0, 8'h20, 2'b11, 16'h0000, 8'h00, 0);

        // read and write together
        xfer(1, 8'h05, 2'b11, 16'h5A5A, 8'h00, 0);
        read = 1; write = 1; address = 8'h05; writedata = 16'hFFFF;
        @(posedge clk); #1;
        read = 0; write = 0;
        m_err = 1;
        chk("err_rw_both", 32'(protocol_error), 32'd1);
        chk("rw_no_count", 32'(nb_writes), 32'(m_writes));
        xfer(0, 8'h05, 2'b11, 16'h0000, 8'h00, 0);
        idle(3);
        chk("end_nb_reads", 32'(nb_reads), 32'(m_reads));
        chk("end_err_sticky", 32'(protocol_error), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        for (int k = 0; k < 80000 && !done_z; k++) @(posedge clk);
        chk("z_done", 32'(done_z), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
